// File: rtl/rv_divide_if.sv
// Handshake and operand bundle between the execute stage and the iterative divider.
interface rv_divide_if;
  logic        d_start_i;
  logic [31:0] d_rs1_i;
  logic [31:0] d_rs2_i;
  logic [2:0]  d_fun_i;
  logic        x_kill_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] w_rd_o;

  modport master (
    output d_start_i, d_rs1_i, d_rs2_i, d_fun_i, x_kill_i,
    input  busy_o, done_o, w_rd_o
  );

  modport slave (
    input  d_start_i, d_rs1_i, d_rs2_i, d_fun_i, x_kill_i,
    output busy_o, done_o, w_rd_o
  );
endinterface

// File: rtl/rv_divide.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), restoring algorithm, one quotient
// bit per clock. The core stalls on busy_o; done_o pulses with w_rd_o valid.
module rv_divide #(
  parameter bit g_bypass_special = 1'b1
) (
  input logic       clk_i,
  input logic       rst_i,
  rv_divide_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [1:0]  fun;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] divisor;
  logic        neg_q;
  logic        neg_r;
  logic [4:0]  count;
  logic [31:0] w_rd;

  logic        accept;
  logic        is_signed;
  logic        divz;
  logic        ovf;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_diff;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] result;

  assign accept    = (state == IDLE || state == DONE) && bus.d_start_i && bus.d_fun_i[2];
  assign is_signed = !fun[0];
  assign divz      = (rs2 == 32'h0000_0000);
  assign ovf       = is_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

  // Shifted partial remainder can reach 33 bits; the difference always fits in 32.
  assign rem_shift = {rem, quo[31]};
  assign rem_ge    = (rem_shift >= {1'b0, divisor});
  assign rem_diff  = rem_shift[31:0] - divisor;

  always_comb begin
    quo_fix = neg_q ? (32'h0000_0000 - quo) : quo;
    rem_fix = neg_r ? (32'h0000_0000 - rem) : rem;
    if (divz) begin
      quo_fix = 32'hFFFF_FFFF;
      rem_fix = rs1;
    end else if (ovf) begin
      quo_fix = 32'h8000_0000;
      rem_fix = 32'h0000_0000;
    end
    result = fun[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Kill overrides every transition, including a start accepted in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = PREP;
      PREP:    state_next = (g_bypass_special && (divz || ovf)) ? FIX : ITER;
      ITER:    if (count == 5'd0) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = accept ? PREP : IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.x_kill_i) state_next = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rs1     <= '0;
      rs2     <= '0;
      fun     <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      count   <= '0;
      w_rd    <= '0;
    end else if (!bus.x_kill_i) begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            rs1 <= bus.d_rs1_i;
            rs2 <= bus.d_rs2_i;
            fun <= bus.d_fun_i[1:0];
          end
        end
        PREP: begin
          quo     <= (is_signed && rs1[31]) ? (32'h0000_0000 - rs1) : rs1;
          divisor <= (is_signed && rs2[31]) ? (32'h0000_0000 - rs2) : rs2;
          rem     <= '0;
          count   <= 5'd31;
          neg_q   <= is_signed && (rs1[31] ^ rs2[31]);
          neg_r   <= is_signed && rs1[31];
        end
        ITER: begin
          rem   <= rem_ge ? rem_diff : rem_shift[31:0];
          quo   <= {quo[30:0], rem_ge};
          count <= count - 5'd1;
        end
        FIX: w_rd <= result;
        default: ;
      endcase
    end
  end

  assign bus.busy_o = (state == PREP) || (state == ITER) || (state == FIX);
  assign bus.done_o = (state == DONE);
  assign bus.w_rd_o = w_rd;

endmodule
